// File: rtl/hardmax_pkg.sv
// hardmax_pkg: shared state encoding and width helpers for the hardmax stream sequencer.
package hardmax_pkg;

    typedef enum logic {ACCUM, DONE} hm_state_t;

    function automatic int fp_width(input int exp_w, input int frac_w);
        return 1 + exp_w + frac_w;
    endfunction

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hardmax_stream_sequencer.sv
// hardmax_stream_sequencer: serial running-max over groups of (V, W, C) triples keyed on C.
// Optional HARDMAX_CONF_THRESH_EN adds thresh_i / low_conf_o low-confidence flagging.
module hardmax_stream_sequencer
    import hardmax_pkg::*;
#(
    parameter int EXP_WIDTH     = 8,
    parameter int FRAC_WIDTH    = 23,
    parameter int NO_CANDIDATES = 4,
    localparam int FP_WIDTH_REG = fp_width(EXP_WIDTH, FRAC_WIDTH),
    localparam int IDX_WIDTH    = idx_width(NO_CANDIDATES)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] v_i,
    input  logic [FP_WIDTH_REG-1:0] w_i,
    input  logic [FP_WIDTH_REG-1:0] c_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [FP_WIDTH_REG-1:0] v_o,
    output logic [FP_WIDTH_REG-1:0] w_o,
    output logic [FP_WIDTH_REG-1:0] c_o,
    output logic [IDX_WIDTH-1:0]    idx_o,
    output logic                    valid_o,
`ifdef HARDMAX_CONF_THRESH_EN
    input  logic [FP_WIDTH_REG-1:0] thresh_i,
    output logic                    low_conf_o,
`endif
    input  logic                    ready_i
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NO_CANDIDATES - 1);

    hm_state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d, idx_q, idx_d;
    logic [FP_WIDTH_REG-1:0] v_q, v_d, w_q, w_d, c_q, c_d;
    logic                    xfer;
`ifdef HARDMAX_CONF_THRESH_EN
    logic                    low_q, low_d;
`endif

    assign ready_o = (state_q == ACCUM) && !rst_i;
    assign valid_o = (state_q == DONE);
    assign xfer    = valid_i && ready_o;
    assign v_o     = v_q;
    assign w_o     = w_q;
    assign c_o     = c_q;
    assign idx_o   = idx_q;
`ifdef HARDMAX_CONF_THRESH_EN
    assign low_conf_o = low_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        v_d     = v_q;
        w_d     = w_q;
        c_d     = c_q;
`ifdef HARDMAX_CONF_THRESH_EN
        low_d   = low_q;
`endif
        if (state_q == ACCUM) begin
            if (xfer) begin
                // first candidate seeds the max; later ones replace only on strictly greater C
                if (cnt_q == '0 || c_i > c_q) begin
                    v_d   = v_i;
                    w_d   = w_i;
                    c_d   = c_i;
                    idx_d = cnt_q;
                end
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef HARDMAX_CONF_THRESH_EN
                    low_d   = c_d < thresh_i;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (ready_i) begin
            state_d = ACCUM;
`ifdef HARDMAX_CONF_THRESH_EN
            low_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            idx_q   <= '0;
            v_q     <= '0;
            w_q     <= '0;
            c_q     <= '0;
`ifdef HARDMAX_CONF_THRESH_EN
            low_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            v_q     <= v_d;
            w_q     <= w_d;
            c_q     <= c_d;
`ifdef HARDMAX_CONF_THRESH_EN
            low_q   <= low_d;
`endif
        end
    end

endmodule

// File: tb/tb_hardmax_stream_sequencer.sv
// tb_hardmax_stream_sequencer: scoreboard bench for the hardmax stream sequencer (default N=4, fp32).
module tb_hardmax_stream_sequencer;

    typedef logic [31:0] word_t;
    typedef struct {
        word_t      v;
        word_t      w;
        word_t      c;
        logic [1:0] idx;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    word_t      v_i = '0, w_i = '0, c_i = '0;
    logic       valid_i = 1'b0, ready_i = 1'b1;
    logic       ready_o, valid_o;
    word_t      v_o, w_o, c_o;
    logic [1:0] idx_o;
`ifdef HARDMAX_CONF_THRESH_EN
    word_t      thresh_i = '0;
    logic       low_conf_o;
`endif

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hardmax_stream_sequencer dut (
        .clk_i(clk), .rst_i(rst),
        .v_i(v_i), .w_i(w_i), .c_i(c_i), .valid_i(valid_i), .ready_o(ready_o),
        .v_o(v_o), .w_o(w_o), .c_o(c_o), .idx_o(idx_o), .valid_o(valid_o),
`ifdef HARDMAX_CONF_THRESH_EN
        .thresh_i(thresh_i), .low_conf_o(low_conf_o),
`endif
        .ready_i(ready_i)
    );

    // Drives one group of four candidates; V/W encode base + position so the winner is identifiable.
    task automatic drive_group(input word_t cs[4], input word_t vb, input int gap);
        res_t e;
        e.c = cs[0];
        e.idx = 2'd0;
        for (int i = 1; i < 4; i++)
            if (cs[i] > e.c) begin
                e.c = cs[i];
                e.idx = 2'(i);
            end
        e.v = vb + 32'(e.idx);
        e.w = ~(vb + 32'(e.idx));
        sb.push_back(e);
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 20 && !ready_o; t++) begin
                @(posedge clk);
                #1;
            end
            v_i = vb + 32'(i);
            w_i = ~(vb + 32'(i));
            c_i = cs[i];
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            valid_i = 1'b0;
            if (i < 3) repeat (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic take(output bit got, output res_t e);
        got = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (valid_o) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({ready_o, valid_o, v_o, w_o, c_o, idx_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b vld=%b v=%h w=%h c=%h idx=%0d, want all 0", ready_o, valid_o, v_o, w_o, c_o, idx_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: rdy=%b vld=%b, want 1 0", ready_o, valid_o);
        end
    endtask

    task automatic test_basic_max();
        word_t cs[4] = '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40000000};
        res_t  e;
        bit    got;
        drive_group(cs, 32'h100, 0);
        n_checks++;
        if (valid_o !== 1'b1 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latency: vld=%b rdy=%b, want 1 0", valid_o, ready_o);
        end
        take(got, e);
        n_checks++;
        if (!got || c_o !== e.c || idx_o !== e.idx) begin
            n_fail++;
            $display("FAIL basic_c_idx: c=%h idx=%0d, want %h %0d", c_o, idx_o, e.c, e.idx);
        end
        n_checks++;
        if (v_o !== e.v || w_o !== e.w) begin
            n_fail++;
            $display("FAIL basic_vw: v=%h w=%h, want %h %h", v_o, w_o, e.v, e.w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        word_t cs[4] = '{32'h3F000000, 32'h3F800000, 32'h40A00000, 32'h3F800000};
        res_t  e;
        bit    got;
        ready_i = 1'b0;
        drive_group(cs, 32'h200, 0);
        take(got, e);
        for (int k = 0; k < 5; k++) begin
            v_i = 32'hDEAD;
            c_i = 32'h7F7FFFFF;
            valid_i = 1'b1;
            @(posedge clk);
            #1;
            n_checks++;
            if (!got || valid_o !== 1'b1 || ready_o !== 1'b0 || c_o !== e.c || idx_o !== e.idx || v_o !== e.v || w_o !== e.w) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: vld=%b rdy=%b c=%h idx=%0d v=%h, want 1 0 %h %0d %h", k, valid_o, ready_o, c_o, idx_o, v_o, e.c, e.idx, e.v);
            end
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_tie();
        word_t cs[4] = '{32'h40000000, 32'h40000000, 32'h3F800000, 32'h40000000};
        res_t  e;
        bit    got;
        drive_group(cs, 32'h300, 0);
        take(got, e);
        n_checks++;
        if (!got || idx_o !== 2'd0 || idx_o !== e.idx || c_o !== e.c || v_o !== e.v || w_o !== e.w) begin
            n_fail++;
            $display("FAIL tie: idx=%0d c=%h v=%h w=%h, want %0d %h %h %h", idx_o, c_o, v_o, w_o, e.idx, e.c, e.v, e.w);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_gapped();
        word_t cs[4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        res_t  e;
        bit    got;
        drive_group(cs, 32'h400, 2);
        take(got, e);
        n_checks++;
        if (!got || idx_o !== 2'd3 || c_o !== 32'h40800000 || v_o !== e.v || w_o !== e.w) begin
            n_fail++;
            $display("FAIL gapped: idx=%0d c=%h v=%h, want 3 40800000 %h", idx_o, c_o, v_o, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_async_reset();
        word_t cs[4] = '{32'h3F000000, 32'h3F800000, 32'h3F400000, 32'h3E800000};
        res_t  e;
        bit    got;
        for (int i = 0; i < 2; i++) begin
            v_i = 32'hBAD0 + 32'(i);
            w_i = 32'hBAD8;
            c_i = 32'h7F000000;
            valid_i = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ready_o, valid_o, v_o, w_o, c_o, idx_o} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: rdy=%b vld=%b v=%h c=%h idx=%0d, want all 0", ready_o, valid_o, v_o, c_o, idx_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive_group(cs, 32'h500, 0);
        take(got, e);
        n_checks++;
        if (!got || idx_o !== 2'd1 || c_o !== e.c || v_o !== e.v || w_o !== e.w) begin
            n_fail++;
            $display("FAIL post_reset_group: idx=%0d c=%h v=%h, want %0d %h %h", idx_o, c_o, v_o, e.idx, e.c, e.v);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        word_t cs[4];
        res_t  e;
        bit    got;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 4; i++) cs[i] = 32'(($urandom_range(0, 3) << 20) | 32'h3F000000);
            drive_group(cs, 32'h1000 * 32'(g + 1), 0);
            take(got, e);
            n_checks++;
            if (!got || idx_o !== e.idx || c_o !== e.c || v_o !== e.v || w_o !== e.w) begin
                n_fail++;
                $display("FAIL b2b[%0d]: idx=%0d c=%h v=%h, want %0d %h %h", g, idx_o, c_o, v_o, e.idx, e.c, e.v);
            end
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HARDMAX_CONF_THRESH_EN
    task automatic test_thresh();
        word_t lo[4] = '{32'h3F800000, 32'h3FC00000, 32'h3F000000, 32'h3F800000};
        word_t hi[4] = '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h40000000};
        res_t  e;
        bit    got;
        thresh_i = 32'h40000000;
        drive_group(lo, 32'h600, 0);
        take(got, e);
        n_checks++;
        if (!got || low_conf_o !== 1'b1 || c_o !== e.c) begin
            n_fail++;
            $display("FAIL thresh_low: low=%b c=%h, want 1 %h", low_conf_o, c_o, e.c);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (low_conf_o !== 1'b0) begin
            n_fail++;
            $display("FAIL thresh_accum: low=%b, want 0", low_conf_o);
        end
        drive_group(hi, 32'h700, 0);
        take(got, e);
        n_checks++;
        if (!got || low_conf_o !== 1'b0 || c_o !== e.c) begin
            n_fail++;
            $display("FAIL thresh_high: low=%b c=%h, want 0 %h", low_conf_o, c_o, e.c);
        end
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_max();
        test_backpressure();
        test_tie();
        test_gapped();
        test_async_reset();
        test_back_to_back();
`ifdef HARDMAX_CONF_THRESH_EN
        test_thresh();
`endif
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
